// File: rtl/disp_pkg.sv
// Shared types and constants for the four-digit multiplexed display scanner.
package disp_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int NIB_W      = 4;
    localparam int VAL_W      = NUM_DIGITS * NIB_W;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    // Segment order {g,f,e,d,c,b,a}, active-high
    typedef logic [6:0] seg7_t;

    localparam seg7_t                 SEG_OFF = 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = '1;

    // A digit above position 0 is suppressed when it and every digit to its
    // left are zero; digit 0 always shows so a zero value still reads "0".
    function automatic logic lz_suppress(input logic [VAL_W-1:0] v,
                                         input logic [IDX_W-1:0] k);
        logic sup;
        sup = (k != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= int'(k)) && (v[i*NIB_W +: NIB_W] != '0)) begin
                sup = 1'b0;
            end
        end
        return sup;
    endfunction

endpackage

// File: rtl/seven_segment_display_deco.sv
// Hex nibble to seven-segment pattern, segments {g,f,e,d,c,b,a} active-high.
module seven_segment_display_deco
    import disp_pkg::*;
(
    input  logic [3:0] hex_i,
    output seg7_t      seg_o
);

    // Pure lookup; glyphs b and d are lower case so they differ from 8 and 0
    always_comb begin
        seg_o = SEG_OFF;
        case (hex_i)
            4'h0: seg_o = 7'h3F;
            4'h1: seg_o = 7'h06;
            4'h2: seg_o = 7'h5B;
            4'h3: seg_o = 7'h4F;
            4'h4: seg_o = 7'h66;
            4'h5: seg_o = 7'h6D;
            4'h6: seg_o = 7'h7D;
            4'h7: seg_o = 7'h07;
            4'h8: seg_o = 7'h7F;
            4'h9: seg_o = 7'h6F;
            4'hA: seg_o = 7'h77;
            4'hB: seg_o = 7'h7C;
            4'hC: seg_o = 7'h39;
            4'hD: seg_o = 7'h5E;
            4'hE: seg_o = 7'h79;
            4'hF: seg_o = 7'h71;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_scan_controller.sv
// Multiplexed four-digit seven-segment scanner with blanking dead time,
// frame-synchronous value update and optional leading-zero suppression.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_BLANK | all anodes off for BLANK_CYCLES before digit idx
//   ST_DRIVE | anode idx on for DWELL_CYCLES showing shadow nibble idx
//
// Both cycle parameters must be at least 1.
module display_scan_controller
    import disp_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [VAL_W-1:0]      value,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    input  logic                  lz_blank,
    output logic [NUM_DIGITS-1:0] an,
    output seg7_t                 seg,
    output logic                  dp,
    output logic                  frame_done,
    output logic                  update_pending
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [VAL_W-1:0]      shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [VAL_W-1:0]      pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_flag_q, pend_flag_d;

    logic [NUM_DIGITS-1:0] an_q, an_d;
    seg7_t                 seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;

    logic                  boundary;
    logic [NIB_W-1:0]      nibble_sel;
    seg7_t                 seg_dec;

    // Last drive cycle of the final digit: the only point where a pending
    // update may move into the shadow while scanning.
    assign boundary = (state_q == ST_DRIVE) && (idx_q == IDX_LAST) && (cnt_q == DWELL_LAST);

    // Decoder looks at the digit about to be shown so its result can be
    // registered alongside the state transition.
    assign nibble_sel = shadow_val_q[{idx_d, 2'b00} +: NIB_W];

    seven_segment_display_deco u_deco (
        .hex_i (nibble_sel),
        .seg_o (seg_dec)
    );

    // Scan sequencing: blank/drive alternation, cycle counter, digit index
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = ST_BLANK;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        idx_d   = idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Double-buffered display data: loads park in pending and move to the
    // shadow only at the frame boundary, or straight through while stopped.
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_flag_d  = pend_flag_q;
        if (!en) begin
            pend_flag_d = 1'b0;
            if (load) begin
                shadow_val_d = value;
                shadow_dp_d  = dp_mask;
            end else if (pend_flag_q) begin
                shadow_val_d = pend_val_q;
                shadow_dp_d  = pend_dp_q;
            end
        end else if (boundary) begin
            pend_flag_d = 1'b0;
            if (load) begin
                shadow_val_d = value;
                shadow_dp_d  = dp_mask;
                pend_val_d   = value;
                pend_dp_d    = dp_mask;
            end else if (pend_flag_q) begin
                shadow_val_d = pend_val_q;
                shadow_dp_d  = pend_dp_q;
            end
        end else if (load) begin
            pend_val_d  = value;
            pend_dp_d   = dp_mask;
            pend_flag_d = 1'b1;
        end
    end

    // Output pins for the next state, so they switch on the same edge
    always_comb begin
        an_d         = AN_OFF;
        seg_d        = SEG_OFF;
        dp_d         = 1'b0;
        frame_done_d = (state_d == ST_DRIVE) && (idx_d == IDX_LAST) && (cnt_d == DWELL_LAST);
        if (state_d == ST_DRIVE) begin
            seg_d = seg_dec;
            dp_d  = shadow_dp_q[idx_d];
            if (!(lz_blank && lz_suppress(shadow_val_q, idx_d))) begin
                an_d = ~(NUM_DIGITS'(1) << idx_d);
            end
        end
    end

    // State, data and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            idx_q        <= '0;
            cnt_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_flag_q  <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_flag_q  <= pend_flag_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an             = an_q;
    assign seg            = seg_q;
    assign dp             = dp_q;
    assign frame_done     = frame_done_q;
    assign update_pending = pend_flag_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with DWELL=4, BLANK=2 (24-cycle frame).
module tb_display_scan_controller;

    logic        clk = 1'b0;
    logic        rst, en, load, lz_blank;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, frame_done, update_pending;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [6:0] exp_seg [4];
    logic [3:0] exp_dp;
    logic [3:0] exp_vis;
    logic [3:0] ea;
    logic [6:0] es;

    always #5 clk = ~clk;

    display_scan_controller #(
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .load           (load),
        .value          (value),
        .dp_mask        (dp_mask),
        .lz_blank       (lz_blank),
        .an             (an),
        .seg            (seg),
        .dp             (dp),
        .frame_done     (frame_done),
        .update_pending (update_pending)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait until the sampled cycle is a frame boundary
    task automatic wait_boundary(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (frame_done !== 1'b1 && n < 60);
        total_cnt++;
        if (frame_done !== 1'b1) $display("FAIL %s_timeout: frame_done never seen in %0d cycles", name, n);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; lz_blank = 1'b0;
        value = 16'h0; dp_mask = 4'h0;
        step(); step();
        total_cnt++; if (an !== 4'b1111) $display("FAIL reset_an: got %b want 1111", an); else pass_cnt++;
        total_cnt++; if (seg !== 7'h00) $display("FAIL reset_seg: got %h want 00", seg); else pass_cnt++;
        total_cnt++; if (dp !== 1'b0) $display("FAIL reset_dp: got %b want 0", dp); else pass_cnt++;
        total_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_fd: got %b want 0", frame_done); else pass_cnt++;
        total_cnt++; if (update_pending !== 1'b0) $display("FAIL reset_up: got %b want 0", update_pending); else pass_cnt++;
    endtask

    task automatic test_scan_order();
        rst = 1'b0; en = 1'b1; load = 1'b1; value = 16'h1234; dp_mask = 4'h0;
        step();
        load = 1'b0;
        total_cnt++; if (update_pending !== 1'b1) $display("FAIL s1_pending: got %b want 1", update_pending); else pass_cnt++;
        wait_boundary("s1");
        exp_seg = '{7'h66, 7'h4F, 7'h5B, 7'h06}; exp_dp = 4'h0; exp_vis = 4'hF;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 6; c++) begin
                step();
                ea = (c < 2 || !exp_vis[k]) ? 4'hF : ~(4'b0001 << k);
                es = (c < 2) ? 7'h00 : exp_seg[k];
                total_cnt++; if (an !== ea) $display("FAIL s1_an d%0d c%0d: got %b want %b", k, c, an, ea); else pass_cnt++;
                total_cnt++; if (seg !== es) $display("FAIL s1_seg d%0d c%0d: got %h want %h", k, c, seg, es); else pass_cnt++;
                total_cnt++; if (frame_done !== (k == 3 && c == 5)) $display("FAIL s1_fd d%0d c%0d: got %b", k, c, frame_done); else pass_cnt++;
            end
        end
        total_cnt++; if (update_pending !== 1'b0) $display("FAIL s1_pending_clr: got %b want 0", update_pending); else pass_cnt++;
    endtask

    task automatic test_free_run();
        int n;
        for (int f = 0; f < 2; f++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (frame_done !== 1'b1 && n < 60);
            total_cnt++; if (n != 24) $display("FAIL s2_period f%0d: got %0d cycles want 24", f, n); else pass_cnt++;
        end
    endtask

    task automatic test_lz_blank();
        lz_blank = 1'b1; load = 1'b1; value = 16'h0070; dp_mask = 4'h0;
        step();
        load = 1'b0;
        wait_boundary("s3");
        exp_seg = '{7'h3F, 7'h07, 7'h3F, 7'h3F}; exp_dp = 4'h0; exp_vis = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 6; c++) begin
                step();
                ea = (c < 2 || !exp_vis[k]) ? 4'hF : ~(4'b0001 << k);
                es = (c < 2) ? 7'h00 : exp_seg[k];
                total_cnt++; if (an !== ea) $display("FAIL s3_an d%0d c%0d: got %b want %b", k, c, an, ea); else pass_cnt++;
                if (c < 2 || exp_vis[k]) begin
                    total_cnt++; if (seg !== es) $display("FAIL s3_seg d%0d c%0d: got %h want %h", k, c, seg, es); else pass_cnt++;
                end
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_last_load_wins();
        step();
        load = 1'b1; value = 16'h1111; dp_mask = 4'h0;
        step();
        load = 1'b0;
        step();
        load = 1'b1; value = 16'h2222; dp_mask = 4'b0101;
        step();
        load = 1'b0;
        total_cnt++; if (update_pending !== 1'b1) $display("FAIL s4_pending: got %b want 1", update_pending); else pass_cnt++;
        wait_boundary("s4");
        exp_seg = '{7'h5B, 7'h5B, 7'h5B, 7'h5B}; exp_dp = 4'b0101; exp_vis = 4'hF;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 6; c++) begin
                step();
                ea = (c < 2) ? 4'hF : ~(4'b0001 << k);
                es = (c < 2) ? 7'h00 : exp_seg[k];
                total_cnt++; if (an !== ea) $display("FAIL s4_an d%0d c%0d: got %b want %b", k, c, an, ea); else pass_cnt++;
                total_cnt++; if (seg !== es) $display("FAIL s4_seg d%0d c%0d: got %h want %h", k, c, seg, es); else pass_cnt++;
                total_cnt++; if (dp !== (c >= 2 && exp_dp[k])) $display("FAIL s4_dp d%0d c%0d: got %b", k, c, dp); else pass_cnt++;
            end
        end
        // now sampled in the boundary cycle: load here must show next frame
        total_cnt++; if (frame_done !== 1'b1) $display("FAIL s4_at_boundary: got %b want 1", frame_done); else pass_cnt++;
        load = 1'b1; value = 16'h5678; dp_mask = 4'b1010;
        exp_seg = '{7'h7F, 7'h07, 7'h7D, 7'h6D}; exp_dp = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 6; c++) begin
                step();
                load = 1'b0;
                ea = (c < 2) ? 4'hF : ~(4'b0001 << k);
                es = (c < 2) ? 7'h00 : exp_seg[k];
                total_cnt++; if (an !== ea) $display("FAIL s4b_an d%0d c%0d: got %b want %b", k, c, an, ea); else pass_cnt++;
                total_cnt++; if (seg !== es) $display("FAIL s4b_seg d%0d c%0d: got %h want %h", k, c, seg, es); else pass_cnt++;
                total_cnt++; if (dp !== (c >= 2 && exp_dp[k])) $display("FAIL s4b_dp d%0d c%0d: got %b", k, c, dp); else pass_cnt++;
            end
        end
        total_cnt++; if (update_pending !== 1'b0) $display("FAIL s4b_pending: got %b want 0", update_pending); else pass_cnt++;
    endtask

    task automatic test_disable();
        int fd_seen;
        int lit_seen;
        step(); step(); step(); step();
        total_cnt++; if (an !== 4'b1110) $display("FAIL s5_pre_an: got %b want 1110", an); else pass_cnt++;
        en = 1'b0;
        step();
        total_cnt++; if (an !== 4'b1111) $display("FAIL s5_off_an: got %b want 1111", an); else pass_cnt++;
        total_cnt++; if (seg !== 7'h00) $display("FAIL s5_off_seg: got %h want 00", seg); else pass_cnt++;
        total_cnt++; if (frame_done !== 1'b0) $display("FAIL s5_off_fd: got %b want 0", frame_done); else pass_cnt++;
        load = 1'b1; value = 16'h0009; dp_mask = 4'h0;
        step();
        load = 1'b0;
        total_cnt++; if (update_pending !== 1'b0) $display("FAIL s5_off_pending: got %b want 0", update_pending); else pass_cnt++;
        fd_seen = 0; lit_seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (frame_done === 1'b1) fd_seen++;
            if (an !== 4'b1111) lit_seen++;
        end
        total_cnt++; if (fd_seen != 0) $display("FAIL s5_fd_while_off: got %0d pulses want 0", fd_seen); else pass_cnt++;
        total_cnt++; if (lit_seen != 0) $display("FAIL s5_lit_while_off: got %0d cycles want 0", lit_seen); else pass_cnt++;
        en = 1'b1;
        total_cnt++; if (an !== 4'b1111) $display("FAIL s5_re_blank0: got %b want 1111", an); else pass_cnt++;
        step();
        total_cnt++; if (an !== 4'b1111) $display("FAIL s5_re_blank1: got %b want 1111", an); else pass_cnt++;
        step();
        total_cnt++; if (an !== 4'b1110) $display("FAIL s5_re_digit0_an: got %b want 1110", an); else pass_cnt++;
        total_cnt++; if (seg !== 7'h6F) $display("FAIL s5_re_digit0_seg: got %h want 6f", seg); else pass_cnt++;
    endtask

    task automatic test_reset_mid_drive();
        load = 1'b1; value = 16'hABCD; dp_mask = 4'hF;
        step();
        load = 1'b0;
        total_cnt++; if (update_pending !== 1'b1) $display("FAIL s6_pending: got %b want 1", update_pending); else pass_cnt++;
        total_cnt++; if (an !== 4'b1110) $display("FAIL s6_in_drive: got %b want 1110", an); else pass_cnt++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++; if (an !== 4'b1111) $display("FAIL s6_rst_an: got %b want 1111", an); else pass_cnt++;
        total_cnt++; if (seg !== 7'h00) $display("FAIL s6_rst_seg: got %h want 00", seg); else pass_cnt++;
        total_cnt++; if (update_pending !== 1'b0) $display("FAIL s6_rst_pending: got %b want 0", update_pending); else pass_cnt++;
        step();
        total_cnt++; if (an !== 4'b1111) $display("FAIL s6_blank: got %b want 1111", an); else pass_cnt++;
        step();
        total_cnt++; if (an !== 4'b1110) $display("FAIL s6_digit0_an: got %b want 1110", an); else pass_cnt++;
        total_cnt++; if (seg !== 7'h3F) $display("FAIL s6_digit0_seg: got %h want 3f", seg); else pass_cnt++;
        total_cnt++; if (dp !== 1'b0) $display("FAIL s6_digit0_dp: got %b want 0", dp); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_free_run();
        test_lz_blank();
        test_last_load_wins();
        test_disable();
        test_reset_mid_drive();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
